// File: rtl/logic_unit.sv
// logic_unit
// Registered N-bit bitwise logic unit with a valid/ready handshake on both sides.
// Eight operations are selected by 'op'. The left operand is either 'c' or the
// previous result, which is kept in 'acc' (chain mode). 'cnt' counts accepted
// operations and wraps at 2^CNT_W.
//
// Optional build macro: LOGIC_UNIT_FLAGS_EN adds the registered 'zero' and
// 'parity' result flags.
//
// Ports:
//   clk        in   1      clock, all state on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      unit can accept this cycle
//   op         in   3      operation select
//   chain      in   1      use previous result instead of 'c'
//   c          in   WIDTH  left operand
//   d          in   WIDTH  right operand
//   out_valid  out  1      'out2' holds a result
//   out_ready  in   1      consumer takes the result this cycle
//   out2       out  WIDTH  registered result
//   cnt        out  CNT_W  number of accepted operations
//   zero       out  1      out2 == 0          (LOGIC_UNIT_FLAGS_EN only)
//   parity     out  1      XOR-reduce of out2 (LOGIC_UNIT_FLAGS_EN only)

module logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out2,
    output logic [CNT_W-1:0] cnt
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] result;
    logic             accept;

    // The output register can take a new result when it is empty or when its
    // current result is being consumed on this same edge.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // acc always holds the most recently accepted result, so a chained op on
    // the very next cycle sees it without a bubble.
    assign left = chain ? acc : c;

    // Operation decode; every result stays exactly WIDTH bits.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = left & d;
            OP_OR:   result = left | d;
            OP_XOR:  result = left ^ d;
            OP_NOR:  result = ~(left | d);
            OP_NAND: result = ~(left & d);
            OP_XNOR: result = ~(left ^ d);
            OP_ANDN: result = left & ~d;
            OP_PASS: result = d;
            default: result = '0;
        endcase
    end

    // Result register, chain accumulator and accept counter. Reset discards a
    // pending result and takes priority over any accept presented that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out2      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out2      <= result;
            acc       <= result;
            cnt       <= cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Flags are computed from the new result so they change on the same edge
    // as out2 and hold whenever out2 holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (accept) begin
            zero   <= ~|result;
            parity <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit
// Scoreboard bench for logic_unit (WIDTH=8, CNT_W=4). Expected results are
// queued as each operation is driven and compared whenever the DUT hands a
// result over (out_valid & out_ready). Flag ports are connected and checked
// only when LOGIC_UNIT_FLAGS_EN is defined.

module tb_logic_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             chain;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out2;
    logic [CNT_W-1:0] cnt;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] modelAcc = '0;
    logic [CNT_W-1:0] modelCnt = '0;

    logic [WIDTH-1:0] allOpsExp [8] = '{8'h4A, 8'hDF, 8'h95, 8'h20,
                                         8'hB5, 8'h6A, 8'h80, 8'h5F};

    logic [WIDTH-1:0] lastOut = '0;

    logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .chain     (chain),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out2      (out2),
        .cnt       (cnt)
`ifdef LOGIC_UNIT_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single checking point for every comparison in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Independent reference for the eight operations.
    function automatic logic [WIDTH-1:0] modelOp(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] l,
                                                 input logic [WIDTH-1:0] r);
        case (o)
            3'd0:    return l & r;
            3'd1:    return l | r;
            3'd2:    return l ^ r;
            3'd3:    return ~(l | r);
            3'd4:    return ~(l & r);
            3'd5:    return ~(l ^ r);
            3'd6:    return l & ~r;
            default: return r;
        endcase
    endfunction

    // Drive one operation (called just after a rising edge), queue its
    // expected result and return just after the edge on which it is accepted.
    task automatic applyStimulus(input logic [2:0] o, input logic ch,
                                 input logic [WIDTH-1:0] cv,
                                 input logic [WIDTH-1:0] dv,
                                 input logic [WIDTH-1:0] expRes);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        op       = o;
        chain    = ch;
        c        = cv;
        d        = dv;
        expQ.push_back(expRes);
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            waitCycles++;
            @(negedge clk);
        end
        if (waitCycles >= 50)
            checkOutput("accept_timeout", 32'(waitCycles), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        modelAcc = expRes;
        modelCnt = modelCnt + 1'b1;
    endtask

    // Synchronous reset pulse; any pending result is discarded.
    task automatic pulseReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        modelAcc = '0;
        modelCnt = '0;
    endtask

    // Scoreboard: compare on every handshake, away from the rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected", 32'(out2), 32'hFFFF_FFFF);
            end else begin
                lastOut = expQ.pop_front();
                checkOutput("sb_out2", 32'(out2), 32'(lastOut));
`ifdef LOGIC_UNIT_FLAGS_EN
                checkOutput("sb_zero", 32'(zero), 32'(lastOut == '0));
                checkOutput("sb_parity", 32'(parity), 32'(^lastOut));
`endif
            end
        end
    end

    initial begin
        logic [2:0]       ro;
        logic             rc;
        logic [WIDTH-1:0] rcv;
        logic [WIDTH-1:0] rdv;
        logic [WIDTH-1:0] rexp;
        int               drain;

        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = 3'd7;
        chain     = 1'b0;
        c         = 8'hAA;
        d         = 8'h55;

        // Reset held two cycles with in_valid high: nothing may be accepted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_cnt", 32'(cnt), 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_out2", 32'(out2), 0);
        checkOutput("rst_valid_after", 32'(out_valid), 0);
        checkOutput("rst_cnt_after", 32'(cnt), 0);
        checkOutput("rst_ready_after", 32'(in_ready), 1);
`ifdef LOGIC_UNIT_FLAGS_EN
        checkOutput("rst_zero", 32'(zero), 1);
        checkOutput("rst_parity", 32'(parity), 0);
`endif
        @(posedge clk);
        #1;

        // All eight ops back-to-back on fixed operands.
        for (int i = 0; i < 8; i++)
            applyStimulus(3'(i), 1'b0, 8'hCA, 8'h5F, allOpsExp[i]);
        @(negedge clk);
        checkOutput("allops_cnt", 32'(cnt), 8);
        @(posedge clk);
        #1;

        // Back-to-back chain: F0, F0&3C=30, 30^FF=CF.
        applyStimulus(3'd7, 1'b0, 8'h00, 8'hF0, 8'hF0);
        applyStimulus(3'd0, 1'b1, 8'hFF, 8'h3C, 8'h30);
        applyStimulus(3'd2, 1'b1, 8'h00, 8'hFF, 8'hCF);

        // Backpressure: 0x12 held for three cycles while a new op waits.
        applyStimulus(3'd7, 1'b0, 8'h00, 8'h12, 8'h12);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd1;
        chain     = 1'b0;
        c         = 8'h40;
        d         = 8'h03;
        expQ.push_back(8'h43);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 0);
            checkOutput("bp_out2", 32'(out2), 32'h12);
            checkOutput("bp_out_valid", 32'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        modelAcc = 8'h43;
        modelCnt = modelCnt + 1'b1;
        checkOutput("bp_valid_stays", 32'(out_valid), 1);
        checkOutput("bp_cnt", 32'(cnt), 32'(modelCnt));
        @(posedge clk);
        #1;

        // Counter wrap: 17 random accepts from a fresh reset leaves cnt at 1.
        pulseReset(1);
        for (int i = 0; i < 17; i++) begin
            ro   = 3'($urandom_range(0, 7));
            rc   = 1'($urandom_range(0, 1));
            rcv  = 8'($urandom);
            rdv  = 8'($urandom);
            rexp = modelOp(ro, rc ? modelAcc : rcv, rdv);
            applyStimulus(ro, rc, rcv, rdv, rexp);
        end
        @(negedge clk);
        checkOutput("wrap_cnt", 32'(cnt), 1);

        // Reset while a result is held: it is dropped and acc clears.
        @(posedge clk);
        #1;
        applyStimulus(3'd7, 1'b0, 8'h00, 8'h77, 8'h77);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("hold_before_rst", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        pulseReset(1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_cnt", 32'(cnt), 0);
        @(posedge clk);
        #1;
        applyStimulus(3'd1, 1'b1, 8'hFF, 8'h00, 8'h00);
        applyStimulus(3'd7, 1'b1, 8'hFF, 8'h00, 8'h00);
`ifdef LOGIC_UNIT_FLAGS_EN
        checkOutput("midrst_zero", 32'(zero), 1);
`endif

        // Flags case: 0x0F ^ 0x0E = 0x01.
        applyStimulus(3'd2, 1'b0, 8'h0F, 8'h0E, 8'h01);
        checkOutput("flags_out2", 32'(out2), 32'h01);
`ifdef LOGIC_UNIT_FLAGS_EN
        checkOutput("flags_zero", 32'(zero), 0);
        checkOutput("flags_parity", 32'(parity), 1);
`endif

        // Let the scoreboard drain.
        drain = 0;
        while (expQ.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        checkOutput("sb_drain", 32'(expQ.size()), 0);
        checkOutput("final_cnt", 32'(cnt), 32'(modelCnt));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
